// File: rtl/ss_dst_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ss_dst_fifo
//  Description : Destination FIFO behind the DMA operation stage. It stores
//                64-bit words with a per-word last flag, shows the head word
//                first-word-fall-through, counts whole frames held and keeps
//                sticky overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module ss_dst_fifo #(
    parameter int DEPTH_LOG2 = 6,
    parameter int AF_MARGIN  = 4,
    parameter int AE_MARGIN  = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  m_flush,
    input  logic                  m_dst_putn,
    input  logic [63:0]           m_dst,
    input  logic                  m_dst_last,
    output logic                  m_dst_full,
    output logic                  m_dst_almost_full,
    input  logic                  fo_getn,
    output logic [63:0]           fo_dout,
    output logic                  fo_last,
    output logic                  fo_empty,
    output logic                  fo_almost_empty,
    output logic [DEPTH_LOG2:0]   fo_count,
    output logic                  fo_frame_rdy,
    output logic                  fo_ovf,
    output logic                  fo_udf
);

    localparam int PW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [CW-1:0] C_FULL_LEVEL = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF_LEVEL   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] C_AE_LEVEL   = CW'(AE_MARGIN);

    logic [64:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] frames_q, frames_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          push_req, pop_req;
    logic          push_ok, pop_ok;
    logic          push_last, pop_last;
    logic [64:0]   head;

    // Flags decode purely from the registered occupancy.
    always_comb begin
        m_dst_full        = (count_q == C_FULL_LEVEL);
        m_dst_almost_full = (count_q >= C_AF_LEVEL);
        fo_empty          = (count_q == '0);
        fo_almost_empty   = (count_q <= C_AE_LEVEL);
        fo_count          = count_q;
        fo_frame_rdy      = (frames_q != '0);
        fo_ovf            = ovf_q;
        fo_udf            = udf_q;
        // Stale array contents are hidden while the FIFO is empty.
        head              = mem_q[rd_ptr_q];
        fo_dout           = fo_empty ? 64'd0 : head[63:0];
        fo_last           = fo_empty ? 1'b0  : head[64];
    end

    // Next-state: pointers, occupancy, frame count and sticky error flags.
    always_comb begin
        push_req  = !m_dst_putn;
        pop_req   = !fo_getn;
        push_ok   = push_req && !m_dst_full;
        pop_ok    = pop_req && !fo_empty;
        push_last = push_ok && m_dst_last;
        pop_last  = pop_ok && fo_last;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        frames_d = frames_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (m_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            frames_d = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);

            if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
            else if (!push_ok && pop_ok) count_d = count_q - CW'(1);

            if (push_last && !pop_last)      frames_d = frames_q + CW'(1);
            else if (!push_last && pop_last) frames_d = frames_q - CW'(1);

            if (push_req && m_dst_full) ovf_d = 1'b1;
            if (pop_req && fo_empty)    udf_d = 1'b1;
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            frames_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            frames_q <= frames_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array; contents need no reset since reads are gated by count.
    always_ff @(posedge wb_clk_i) begin
        if (push_ok && !m_flush) begin
            mem_q[wr_ptr_q] <= {m_dst_last, m_dst};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ss_dst_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ss_dst_fifo
//  Description : Self-checking bench for ss_dst_fifo. A queue-based model of
//                the FIFO is stepped every clock and all outputs are compared
//                against it after each edge; directed scenarios are followed
//                by a randomized traffic phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ss_dst_fifo;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic        m_flush;
    logic        m_dst_putn;
    logic [63:0] m_dst;
    logic        m_dst_last;
    logic        m_dst_full;
    logic        m_dst_almost_full;
    logic        fo_getn;
    logic [63:0] fo_dout;
    logic        fo_last;
    logic        fo_empty;
    logic        fo_almost_empty;
    logic [6:0]  fo_count;
    logic        fo_frame_rdy;
    logic        fo_ovf;
    logic        fo_udf;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [64:0] mq [$];
    logic        m_ovf;
    logic        m_udf;

    ss_dst_fifo #(.DEPTH_LOG2(6), .AF_MARGIN(4), .AE_MARGIN(4)) dut (
        .wb_clk_i          (clk),
        .wb_rst_ni         (rst_n),
        .m_flush           (m_flush),
        .m_dst_putn        (m_dst_putn),
        .m_dst             (m_dst),
        .m_dst_last        (m_dst_last),
        .m_dst_full        (m_dst_full),
        .m_dst_almost_full (m_dst_almost_full),
        .fo_getn           (fo_getn),
        .fo_dout           (fo_dout),
        .fo_last           (fo_last),
        .fo_empty          (fo_empty),
        .fo_almost_empty   (fo_almost_empty),
        .fo_count          (fo_count),
        .fo_frame_rdy      (fo_frame_rdy),
        .fo_ovf            (fo_ovf),
        .fo_udf            (fo_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frames_held();
        int n = 0;
        foreach (mq[i]) if (mq[i][64]) n++;
        return n;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Apply one clock edge worth of behaviour to the model, using the inputs
    // as they were presented at that edge.
    task automatic model_edge();
        bit full_b, empty_b, do_push, do_pop;
        logic [64:0] w;
        if (!rst_n || m_flush) begin
            model_clear();
        end else begin
            full_b  = (mq.size() == DEPTH);
            empty_b = (mq.size() == 0);
            do_push = !m_dst_putn && !full_b;
            do_pop  = !fo_getn && !empty_b;
            if (!m_dst_putn && full_b) m_ovf = 1'b1;
            if (!fo_getn && empty_b)   m_udf = 1'b1;
            if (do_pop)  w = mq.pop_front();
            if (do_push) mq.push_back({m_dst_last, m_dst});
        end
    endtask

    task automatic check_all();
        int sz = mq.size();
        check_eq("count",        64'(fo_count),          64'(sz));
        check_eq("empty",        64'(fo_empty),          64'(sz == 0));
        check_eq("full",         64'(m_dst_full),        64'(sz == DEPTH));
        check_eq("almost_full",  64'(m_dst_almost_full), 64'(sz >= DEPTH - 4));
        check_eq("almost_empty", 64'(fo_almost_empty),   64'(sz <= 4));
        check_eq("frame_rdy",    64'(fo_frame_rdy),      64'(frames_held() != 0));
        check_eq("ovf",          64'(fo_ovf),            64'(m_ovf));
        check_eq("udf",          64'(fo_udf),            64'(m_udf));
        check_eq("dout",         fo_dout,                (sz == 0) ? 64'd0 : mq[0][63:0]);
        check_eq("last",         64'(fo_last),           (sz == 0) ? 64'd0 : 64'(mq[0][64]));
    endtask

    // One clock: inputs already set; model follows the edge, outputs checked 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        m_flush    = 1'b0;
        m_dst_putn = 1'b1;
        fo_getn    = 1'b1;
        m_dst      = '0;
        m_dst_last = 1'b0;
    endtask

    task automatic push(input logic [63:0] d, input logic l);
        idle();
        m_dst_putn = 1'b0;
        m_dst      = d;
        m_dst_last = l;
        step();
    endtask

    task automatic pop();
        idle();
        fo_getn = 1'b0;
        step();
    endtask

    task automatic flush();
        idle();
        m_flush = 1'b1;
        step();
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_clear();
        #3;
        check_all();
        step();
        rst_n = 1'b1;
        step();

        // Fill completely; flags follow the model every cycle.
        for (int i = 1; i <= 64; i++) begin
            push(64'(i), i == 64);
            if (i == 59) check_eq("af_before_60", 64'(m_dst_almost_full), 64'd0);
            if (i == 60) check_eq("af_at_60", 64'(m_dst_almost_full), 64'd1);
        end
        check_eq("full_at_64", 64'(m_dst_full), 64'd1);

        // Overflow attempt, alone and together with a pop.
        push(64'hDEAD, 1'b0);
        check_eq("ovf_set", 64'(fo_ovf), 64'd1);
        check_eq("count_held", 64'(fo_count), 64'd64);
        idle();
        m_dst_putn = 1'b0;
        m_dst      = 64'hBEEF;
        fo_getn    = 1'b0;
        step();
        check_eq("full_pop_push_count", 64'(fo_count), 64'd63);

        // Drain; order and last flag come from the model.
        for (int i = 0; i < 63; i++) pop();
        check_eq("drained_empty", 64'(fo_empty), 64'd1);
        check_eq("drained_frames", 64'(fo_frame_rdy), 64'd0);

        // Pop on empty alongside a push.
        idle();
        m_dst_putn = 1'b0;
        m_dst      = 64'hA5;
        fo_getn    = 1'b0;
        step();
        check_eq("udf_set", 64'(fo_udf), 64'd1);
        check_eq("a5_head", fo_dout, 64'hA5);
        check_eq("a5_count", 64'(fo_count), 64'd1);

        // Steady stream at depth 10.
        flush();
        for (int i = 0; i < 10; i++) push(64'($urandom), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 200; i++) begin
            idle();
            m_dst_putn = 1'b0;
            fo_getn    = 1'b0;
            m_dst      = {$urandom, $urandom};
            m_dst_last = 1'($urandom_range(0, 1));
            step();
        end
        check_eq("stream_count", 64'(fo_count), 64'd10);

        // Frame accounting.
        flush();
        for (int f = 0; f < 3; f++)
            for (int w = 0; w < 5; w++) push(64'(100 * f + w), w == 4);
        for (int i = 0; i < 5; i++) pop();
        check_eq("frames_two_left", 64'(fo_frame_rdy), 64'd1);
        for (int i = 0; i < 10; i++) pop();
        check_eq("frames_none", 64'(fo_frame_rdy), 64'd0);

        // Flush mid-traffic with overflow set, push and pop also requested.
        for (int i = 0; i < 65; i++) push(64'($urandom), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 27; i++) pop();
        check_eq("pre_flush_count", 64'(fo_count), 64'd37);
        idle();
        m_flush    = 1'b1;
        m_dst_putn = 1'b0;
        fo_getn    = 1'b0;
        m_dst      = 64'h1234;
        step();
        check_eq("flush_ovf_clear", 64'(fo_ovf), 64'd0);
        push(64'h5151, 1'b0);
        check_eq("post_flush_head", fo_dout, 64'h5151);

        // Asynchronous reset asserted between edges while pushing.
        push(64'h6161, 1'b1);
        idle();
        m_dst_putn = 1'b0;
        m_dst      = 64'h7777;
        rst_n      = 1'b0;
        model_clear();
        #1;
        check_all();
        step();
        rst_n = 1'b1;
        push(64'h8181, 1'b0);
        check_eq("post_reset_head", fo_dout, 64'h8181);

        // Randomized traffic with varying push/pop pressure.
        for (int e = 0; e < 12; e++) begin
            int pp = $urandom_range(10, 90);
            int gp = $urandom_range(10, 90);
            for (int c = 0; c < 250; c++) begin
                idle();
                m_dst_putn = !($urandom_range(0, 99) < pp);
                fo_getn    = !($urandom_range(0, 99) < gp);
                m_dst      = {$urandom, $urandom};
                m_dst_last = ($urandom_range(0, 3) == 0);
                m_flush    = ($urandom_range(0, 299) == 0);
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
